// File: rtl/frb_burst_scheduler_pkg.sv
// rtl/frb_burst_scheduler_pkg.sv - shared state encoding and parameter defaults for the FRB burst scheduler
package frb_burst_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int CNT_W_DEF = 16;
    localparam int DEC_W_DEF = 32;
    localparam int GAP_W_DEF = 32;

endpackage

// File: rtl/frb_gap_timer.sv
// rtl/frb_gap_timer.sv - loadable inter-burst gap down-counter with zero flag
module frb_gap_timer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         tick,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (tick && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/frb_burst_scheduler.sv
// rtl/frb_burst_scheduler.sv - sequences address-counter bursts with programmable gap and count
module frb_burst_scheduler
    import frb_burst_scheduler_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int DEC_W = DEC_W_DEF,
    parameter int GAP_W = GAP_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [DEC_W-1:0] cfg_decimate,
    input  logic [GAP_W-1:0] cfg_gap,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic             ctr_finish,
    output logic             ctr_en,
    output logic [DEC_W-1:0] ctr_decimate,
    output logic             busy,
    output logic [CNT_W-1:0] burst_idx,
    output logic             done,
    output logic             cfg_err
);

    state_t           state;
    logic [GAP_W-1:0] gap_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] idx_next;
    logic             last_burst;
    logic             gap_load;
    logic             gap_tick;
    logic             gap_zero;

    // count_r == 0 means free-running, so idx_next may wrap without ending the sequence
    assign idx_next   = burst_idx + CNT_W'(1);
    assign last_burst = (count_r != '0) && (idx_next == count_r);
    assign gap_load   = (state == ST_PLAY) && ctr_finish && !stop && !last_burst;
    assign gap_tick   = (state == ST_GAP) && !stop;

    frb_gap_timer #(.W(GAP_W)) u_gap_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (gap_load),
        .load_value (gap_r),
        .tick       (gap_tick),
        .zero       (gap_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            ctr_en       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            cfg_err      <= 1'b0;
            burst_idx    <= '0;
            ctr_decimate <= '0;
            gap_r        <= '0;
            count_r      <= '0;
        end else begin
            done    <= 1'b0;
            cfg_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !stop) begin
                        if (cfg_decimate != '0) begin
                            ctr_decimate <= cfg_decimate;
                            gap_r        <= cfg_gap;
                            count_r      <= cfg_count;
                            burst_idx    <= '0;
                            state        <= ST_PLAY;
                            ctr_en       <= 1'b1;
                            busy         <= 1'b1;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                ST_PLAY: begin
                    if (stop) begin
                        state  <= ST_IDLE;
                        ctr_en <= 1'b0;
                        busy   <= 1'b0;
                    end else if (ctr_finish) begin
                        burst_idx <= idx_next;
                        ctr_en    <= 1'b0;
                        if (last_burst) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (stop) begin
                        state  <= ST_IDLE;
                        ctr_en <= 1'b0;
                        busy   <= 1'b0;
                    end else if (gap_zero) begin
                        state  <= ST_PLAY;
                        ctr_en <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    ctr_en <= 1'b0;
                    busy   <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    ctr_en <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frb_burst_scheduler.sv
// tb/tb_frb_burst_scheduler.sv - directed vector bench for frb_burst_scheduler
module tb_frb_burst_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] cfg_decimate = '0;
    logic [31:0] cfg_gap = '0;
    logic [15:0] cfg_count = '0;
    logic        ctr_finish = 1'b0;
    logic        ctr_en;
    logic [31:0] ctr_decimate;
    logic        busy;
    logic [15:0] burst_idx;
    logic        done;
    logic        cfg_err;

    int n_chk = 0;
    int n_fail = 0;

    frb_burst_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .cfg_decimate (cfg_decimate),
        .cfg_gap      (cfg_gap),
        .cfg_count    (cfg_count),
        .ctr_finish   (ctr_finish),
        .ctr_en       (ctr_en),
        .ctr_decimate (ctr_decimate),
        .busy         (busy),
        .burst_idx    (burst_idx),
        .done         (done),
        .cfg_err      (cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, start, stop, finish;
        logic [31:0] dec, gap;
        logic [15:0] cnt;
        logic        en, busy, done, err;
        logic [15:0] idx;
        logic [31:0] dout;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        start = 0; stop = 0; ctr_finish = 0;
        rst = 1;
        step();
        rst = 0;
        step();
    endtask

    // Drives ctr_finish after run_len enable cycles per burst, optional stop after stop_after bursts
    task automatic run_bursts(input int run_len, input int stop_after, input int exp_low,
                              input int exp_windows, input int exp_dones, input int exp_idx);
        int   run = 0, low = 0, windows = 0, falls = 0, dones = 0;
        logic prev_en = 1'b0;
        logic ended = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            ctr_finish = 0;
            stop = 0;
            if (ctr_en) begin
                if (!prev_en) begin
                    windows++;
                    if (windows > 1) chk("gap_low_cycles", low, exp_low);
                end
                run++;
                if (run == run_len) ctr_finish = 1;
            end else if (busy || prev_en) begin
                if (prev_en) begin
                    falls++;
                    chk("burst_len", run, run_len);
                    chk("idx_after_burst", burst_idx, falls);
                    run = 0;
                    low = 0;
                    if (falls == stop_after) stop = 1;
                end
                low++;
            end
            if (done) dones++;
            prev_en = ctr_en;
            if (!busy) begin
                ended = 1'b1;
                break;
            end
            step();
        end
        ctr_finish = 0;
        stop = 0;
        chk("seq_ended", ended, 1);
        chk("windows", windows, exp_windows);
        chk("done_pulses", dones, exp_dones);
        chk("final_idx", burst_idx, exp_idx);
        chk("final_ctr_en", ctr_en, 0);
    endtask

    initial begin
        int   low;
        int   k;
        logic seen_done;

        //            rst st sp fn dec gap cnt | en bz dn er idx dout
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 1, 0, 0, 0, 4, 2,   0, 0, 0, 1, 0, 0};
        tbl[3]  = '{0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0};
        tbl[4]  = '{0, 1, 1, 0, 7, 1, 2,   0, 0, 0, 0, 0, 0};
        tbl[5]  = '{0, 1, 0, 0, 7, 1, 2,   1, 1, 0, 0, 0, 7};
        tbl[6]  = '{0, 0, 0, 1, 7, 1, 2,   0, 1, 0, 0, 1, 7};
        tbl[7]  = '{0, 0, 0, 1, 7, 1, 2,   0, 1, 0, 0, 1, 7};
        tbl[8]  = '{0, 0, 0, 0, 7, 1, 2,   1, 1, 0, 0, 1, 7};
        tbl[9]  = '{0, 0, 0, 1, 7, 1, 2,   0, 1, 1, 0, 2, 7};
        tbl[10] = '{0, 0, 0, 0, 7, 1, 2,   0, 0, 0, 0, 2, 7};
        tbl[11] = '{0, 1, 0, 0, 9, 0, 0,   1, 1, 0, 0, 0, 9};
        tbl[12] = '{0, 0, 1, 0, 9, 0, 0,   0, 0, 0, 0, 0, 9};

        #1;
        for (int i = 0; i < 13; i++) begin
            rst = tbl[i].rst; start = tbl[i].start; stop = tbl[i].stop;
            ctr_finish = tbl[i].finish; cfg_decimate = tbl[i].dec;
            cfg_gap = tbl[i].gap; cfg_count = tbl[i].cnt;
            step();
            chk($sformatf("v%0d_ctr_en", i), ctr_en, tbl[i].en);
            chk($sformatf("v%0d_busy", i), busy, tbl[i].busy);
            chk($sformatf("v%0d_done", i), done, tbl[i].done);
            chk($sformatf("v%0d_cfg_err", i), cfg_err, tbl[i].err);
            chk($sformatf("v%0d_burst_idx", i), burst_idx, tbl[i].idx);
            chk($sformatf("v%0d_ctr_decimate", i), ctr_decimate, tbl[i].dout);
        end
        rst = 0; start = 0; stop = 0; ctr_finish = 0;

        // three bursts of 20, gap 5
        do_reset();
        cfg_decimate = 2; cfg_gap = 5; cfg_count = 3; start = 1;
        step();
        start = 0;
        run_bursts(20, 0, 6, 3, 1, 3);

        // free-running, zero gap, stopped after four bursts
        do_reset();
        cfg_decimate = 1; cfg_gap = 0; cfg_count = 0; start = 1;
        step();
        start = 0;
        run_bursts(3, 4, 1, 4, 0, 4);

        // asynchronous reset mid-burst
        do_reset();
        cfg_decimate = 4; cfg_gap = 2; cfg_count = 0; start = 1;
        step();
        start = 0;
        step(); step(); step();
        ctr_finish = 1;
        step();
        ctr_finish = 0;
        step(); step(); step();
        chk("rst_pre_ctr_en", ctr_en, 1);
        chk("rst_pre_idx", burst_idx, 1);
        #2 rst = 1;
        #1;
        chk("rst_async_ctr_en", ctr_en, 0);
        chk("rst_async_busy", busy, 0);
        chk("rst_async_idx", burst_idx, 0);
        chk("rst_async_decimate", ctr_decimate, 0);
        step();
        rst = 0;
        seen_done = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (done) seen_done = 1;
        end
        chk("rst_release_done", seen_done, 0);
        chk("rst_release_busy", busy, 0);
        chk("rst_release_ctr_en", ctr_en, 0);

        // start with new config during GAP must be ignored
        do_reset();
        cfg_decimate = 3; cfg_gap = 10; cfg_count = 5; start = 1;
        step();
        start = 0;
        chk("gapstart_play", ctr_en, 1);
        ctr_finish = 1;
        step();
        ctr_finish = 0;
        chk("gapstart_idx1", burst_idx, 1);
        cfg_decimate = 8; cfg_gap = 0; cfg_count = 1; start = 1;
        step();
        start = 0;
        chk("gapstart_decimate_held", ctr_decimate, 3);
        chk("gapstart_busy", busy, 1);
        chk("gapstart_ctr_en", ctr_en, 0);
        low = 2;
        k = 0;
        while (!ctr_en && k < 50) begin
            step();
            if (!ctr_en) low++;
            k++;
        end
        chk("gapstart_resumed", ctr_en, 1);
        chk("gapstart_low_cycles", low, 11);
        ctr_finish = 1;
        step();
        ctr_finish = 0;
        chk("gapstart_idx2", burst_idx, 2);
        chk("gapstart_no_done", done, 0);
        chk("gapstart_still_busy", busy, 1);
        step();
        stop = 1;
        step();
        stop = 0;
        chk("gapstart_stop_busy", busy, 0);
        chk("gapstart_stop_idx", burst_idx, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/frb_burst_scheduler.md
FRB_BURST_SCHEDULER -- requirements
Module: frb_burst_scheduler

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of burst count and burst index.
REQ-002 SHALL have parameter DEC_W, default 32: width of decimate value passed to the address counter.
REQ-003 SHALL have parameter GAP_W, default 32: width of inter-burst gap counter.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  single-cycle request to begin a burst sequence.
REQ-007 stop  in  1  single-cycle abort request.
REQ-008 cfg_decimate  in  DEC_W  playback decimation for the address counter.
REQ-009 cfg_gap  in  GAP_W  idle cycles between end of one burst and start of next.
REQ-010 cfg_count  in  CNT_W  bursts per sequence; 0 = run until stop.
REQ-011 ctr_finish  in  1  address-counter end-of-table pulse.
REQ-012 ctr_en  out  1  enable to address counter.
REQ-013 ctr_decimate  out  DEC_W  latched decimate to address counter.
REQ-014 busy  out  1  high in any state except IDLE.
REQ-015 burst_idx  out  CNT_W  number of bursts completed in current sequence.
REQ-016 done  out  1  one-cycle pulse when the sequence completes normally.
REQ-017 cfg_err  out  1  one-cycle pulse when start is rejected.

Function
REQ-018 FSM states SHALL be IDLE, PLAY, GAP, DONE; registered outputs only.
REQ-019 IDLE + start, cfg_decimate!=0: latch cfg_decimate/cfg_gap/cfg_count, clear burst_idx, next state PLAY; ctr_en high from the next cycle.
REQ-020 IDLE + start with cfg_decimate==0: stay IDLE, pulse cfg_err next cycle, latch nothing.
REQ-021 start while busy SHALL be ignored; cfg_* changes after latching SHALL have no effect until next accepted start.
REQ-022 PLAY: ctr_en=1 continuously; ctr_finish high -> burst_idx+1 and ctr_en=0 on the next cycle.
REQ-023 on finish, if cfg_count!=0 and burst_idx+1==cfg_count -> DONE, else -> GAP with gap counter loaded with cfg_gap.
REQ-024 GAP: ctr_en=0, counter decrements each cycle; counter==0 -> PLAY; cfg_gap=0 yields exactly one GAP cycle (ctr_en low one cycle).
REQ-025 DONE: done=1 for one cycle, then IDLE; burst_idx holds its final value until the next accepted start.
REQ-026 ctr_finish outside PLAY SHALL be ignored.
REQ-027 stop in any busy state: next state IDLE, ctr_en=0 next cycle, no done pulse, burst_idx holds.
REQ-028 start and stop in the same cycle: stop wins; start is discarded.
REQ-029 cfg_count==0: burst_idx wraps modulo 2^CNT_W with no side effect; sequence ends only by stop.
REQ-030 ctr_decimate SHALL hold the latched value at all times, including IDLE.

Reset
REQ-031 rst SHALL force IDLE immediately; ctr_en, busy, done, cfg_err = 0; burst_idx, ctr_decimate, gap counter, latched config = 0.
REQ-032 rst asserted mid-burst SHALL drop ctr_en without waiting for ctr_finish; no done pulse on release.

Structure
REQ-033 FSM state encoding and parameter defaults SHALL live in the shared synthetic-FRB package.
REQ-034 Gap down-counter SHALL be one sub-module, frb_gap_timer (load, tick, zero flag); everything else flat.

Verification
REQ-035 cfg_count=3, cfg_gap=5, decimate=2, finish every 20 cycles of ctr_en -> three ctr_en windows, 6 low cycles between (1 transition + 5 gap), burst_idx 1,2,3, single done pulse.
REQ-036 start with cfg_decimate=0 -> cfg_err pulse, busy stays 0, ctr_en stays 0.
REQ-037 cfg_count=0, cfg_gap=0, stop after 4 finishes -> ctr_en low 1 cycle between bursts, burst_idx=4, no done.
REQ-038 rst asserted during PLAY -> ctr_en and busy 0 same cycle, all counters 0.
REQ-039 start+stop same cycle from IDLE -> stays IDLE; start during GAP with new cfg -> ignored, latched values unchanged.
